random_num_gen_63: RTL and testbench

//  6-bit maximal-length Fibonacci LFSR pseudo-random source, period 63 (all states except 0).

---
 rtl/random_num_gen_63_pkg.sv | 17 +
 rtl/random_num_gen_63_mod_unit.sv | 24 ++
 rtl/random_num_gen_63.sv | 54 +++++
 tb/tb_random_num_gen_63.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/random_num_gen_63_pkg.sv
// Shared constants and the LFSR step rule for the 63-period apple coordinate generator.
// Taps implement x^6 + x^5 + 1, so the step rule is only valid for a 6-bit state.
package random_num_gen_63_pkg;

    localparam int          LFSR_WIDTH   = 6;
    localparam logic [5:0]  DEFAULT_SEED = 6'b100110;
    localparam int          TAP_HI       = 5;
    localparam int          TAP_LO       = 4;
    localparam int          PERIOD       = 63;
    localparam logic [5:0]  STEP_LAST    = 6'd62;
    localparam logic [5:0]  ZERO_SUB     = 6'b000001;

    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] cur);
        return {cur[LFSR_WIDTH-2:0], cur[TAP_HI] ^ cur[TAP_LO]};
    endfunction

endpackage

// File: rtl/random_num_gen_63_mod_unit.sv
// Combinational unsigned remainder value % limit as an unrolled restoring divider.
// A zero limit passes the value straight through.
module random_num_gen_63_mod_unit #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH:0] partial;

    always_comb begin
        partial = '0;
        for (int i = WIDTH-1; i >= 0; i--) begin
            partial = {partial[WIDTH-1:0], value[i]};
            if (partial >= {1'b0, limit}) begin
                partial = partial - {1'b0, limit};
            end
        end
        remainder = (limit == '0) ? value : partial[WIDTH-1:0];
    end

endmodule

// File: rtl/random_num_gen_63.sv
// 6-bit Fibonacci LFSR source with reseed, range-reduced output and a period-wrap pulse.
// One instance per screen axis; instances differ only by RESET_SEED.
module random_num_gen_63
    import random_num_gen_63_pkg::*;
#(
    parameter int         WIDTH      = LFSR_WIDTH,
    parameter logic [5:0] RESET_SEED = DEFAULT_SEED
) (
    input  logic             vga_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] rnd,
    output logic [WIDTH-1:0] rnd_fit,
    output logic             wrap
);

    // Steps remaining before the sequence returns to its start state.
    logic [5:0] steps_left;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            rnd        <= RESET_SEED;
            steps_left <= STEP_LAST;
            wrap       <= 1'b0;
        end else if (load) begin
            rnd        <= (seed == '0) ? ZERO_SUB : seed;
            steps_left <= STEP_LAST;
            wrap       <= 1'b0;
        end else if (en) begin
            rnd <= lfsr_step(rnd);
            if (steps_left == '0) begin
                steps_left <= STEP_LAST;
                wrap       <= 1'b1;
            end else begin
                steps_left <= steps_left - 6'd1;
                wrap       <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

    random_num_gen_63_mod_unit #(
        .WIDTH(WIDTH)
    ) u_mod_unit (
        .value    (rnd),
        .limit    (limit),
        .remainder(rnd_fit)
    );

endmodule

// File: tb/tb_random_num_gen_63.sv
// Bench for random_num_gen_63: directed cases plus randomized en/load/seed/limit traffic
// compared each cycle against an arithmetic model of the LFSR, step count and remainder.
module tb_random_num_gen_63;

    logic       vga_clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [5:0] seed;
    logic [5:0] limit;
    logic [5:0] rnd;
    logic [5:0] rnd_fit;
    logic       wrap;

    int checks   = 0;
    int failures = 0;

    int m_rnd;
    int m_steps;
    int m_wrap;

    random_num_gen_63 dut (
        .vga_clk(vga_clk),
        .reset  (reset),
        .en     (en),
        .load   (load),
        .seed   (seed),
        .limit  (limit),
        .rnd    (rnd),
        .rnd_fit(rnd_fit),
        .wrap   (wrap)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int next_val(input int r);
        int fb;
        fb = ((r / 32) + (r / 16)) % 2;
        return ((r * 2) % 64) + fb;
    endfunction

    function automatic int fit_of(input int r, input int lim);
        return (lim == 0) ? r : r % lim;
    endfunction

    task automatic model_reset();
        m_rnd   = 38;
        m_steps = 0;
        m_wrap  = 0;
    endtask

    task automatic model_edge(input int e, input int ld, input int sd);
        if (ld != 0) begin
            m_rnd   = (sd == 0) ? 1 : sd;
            m_steps = 0;
            m_wrap  = 0;
        end else if (e != 0) begin
            m_rnd   = next_val(m_rnd);
            m_steps = m_steps + 1;
            m_wrap  = (m_steps % 63 == 0) ? 1 : 0;
        end else begin
            m_wrap = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".rnd"},     int'(rnd),     m_rnd);
        chk({tag, ".rnd_fit"}, int'(rnd_fit), fit_of(m_rnd, int'(limit)));
        chk({tag, ".wrap"},    int'(wrap),    m_wrap);
    endtask

    // Inputs are already set; take one edge, advance the model, sample 1 unit later.
    task automatic tick();
        int e, ld, sd;
        e  = int'(en);
        ld = int'(load);
        sd = int'(seed);
        @(posedge vga_clk);
        model_edge(e, ld, sd);
        #1;
    endtask

    initial begin
        bit seen [64];
        int seen_cnt;
        int wrap_cnt;
        int wrap_at;
        int hold_val;
        int expected_seq [4];

        reset = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        seed  = 6'd0;
        limit = 6'd0;
        model_reset();
        #12;
        compare_all("reset");
        chk("reset.rnd_const", int'(rnd), 38);
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
        tick();
        compare_all("released_hold");

        // First steps from the reset seed against literal values.
        expected_seq = '{6'b001101, 6'b011010, 6'b110101, 6'b101010};
        en = 1'b1;
        foreach (expected_seq[i]) begin
            tick();
            chk($sformatf("seq%0d", i), int'(rnd), expected_seq[i]);
        end

        // Full period from reset: every nonzero value once, single wrap pulse.
        reset = 1'b1;
        #1;
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < 64; i++) seen[i] = 1'b0;
        seen[38] = 1'b1;
        seen_cnt = 1;
        wrap_cnt = 0;
        wrap_at  = -1;
        en = 1'b1;
        for (int i = 1; i <= 63; i++) begin
            tick();
            if (wrap) begin
                wrap_cnt++;
                wrap_at = i;
            end
            if (i < 63) begin
                chk("period.unique", int'(seen[rnd]), 0);
                seen[rnd] = 1'b1;
                seen_cnt++;
            end
        end
        chk("period.nonzero_seen", seen_cnt - int'(seen[0]), 63);
        chk("period.wrap_count", wrap_cnt, 1);
        chk("period.wrap_step", wrap_at, 63);
        chk("period.back_to_seed", int'(rnd), 38);
        en = 1'b0;
        tick();
        chk("period.wrap_one_cycle", int'(wrap), 0);

        // Reseed cases.
        load = 1'b1;
        seed = 6'd0;
        tick();
        chk("load_zero", int'(rnd), 1);
        en   = 1'b1;
        seed = 6'd5;
        tick();
        chk("load_en", int'(rnd), 5);
        compare_all("load_en");
        load = 1'b0;
        en   = 1'b0;

        // Remainder boundaries at rnd = 26.
        load = 1'b1;
        seed = 6'd26;
        tick();
        load  = 1'b0;
        limit = 6'd10;
        #1;
        chk("fit_lim10", int'(rnd_fit), 6);
        limit = 6'd0;
        #1;
        chk("fit_lim0", int'(rnd_fit), 26);
        limit = 6'd1;
        #1;
        chk("fit_lim1", int'(rnd_fit), 0);
        limit = 6'd27;
        #1;
        chk("fit_lim27", int'(rnd_fit), 26);

        // Hold with en low.
        hold_val = int'(rnd);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold.rnd", int'(rnd), hold_val);
            chk("hold.wrap", int'(wrap), 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            load  = ($urandom_range(0, 15) == 0);
            seed  = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
            limit = 6'($urandom_range(0, 63));
            tick();
            compare_all("rand");
        end
        load = 1'b0;

        // Async reset between edges, then a full period before the next wrap.
        en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_reset.rnd", int'(rnd), 38);
        chk("async_reset.wrap", int'(wrap), 0);
        reset = 1'b0;
        wrap_cnt = 0;
        wrap_at  = -1;
        for (int i = 1; i <= 63; i++) begin
            limit = 6'($urandom_range(0, 63));
            tick();
            compare_all("after_reset");
            if (wrap) begin
                wrap_cnt++;
                wrap_at = i;
            end
        end
        chk("after_reset.wrap_count", wrap_cnt, 1);
        chk("after_reset.wrap_step", wrap_at, 63);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
